uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver: the receive-side counterpart of `uart_tx`, sharing its `Clock`/`Baud`/`Stop` parameterisation and 8N-style framing (1 start bit, 8 data bits LSB first, no parity, `Stop` stop bits). It synchronises the `rxd` pin, validates the start bit at mid-bit, samples data and stop bits at mid-bit and presents each received byte on a ready/acknowledge holding register with framing and overrun error flags. It sits between the board UART pin and any byte-consuming logic.

## Interface
- `Clock`, 50000000: system clock frequency in Hz.
- `Baud`, 9600: bit rate.
- `Stop`, 1: number of stop bits checked, legal range 1..4.
- Derived: `Ticks = Clock / Baud` (integer truncation; 5208 at defaults), `Half = Ticks / 2` (2604).

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial input; idle high; asynchronous to `clock`.
- `ack` in 1: consumer acknowledge; clears `rdy`, `ferr` and `oerr`.
- `data` out 8: last good received byte.
- `rdy` out 1: `data` holds an unacknowledged byte.
- `ferr` out 1: sticky framing error (a stop bit sampled low).
- `oerr` out 1: sticky overrun (a frame completed while `rdy` = 1).

## Operation
- Reset (`reset` = 0) gives `data` = 0, `rdy` = `ferr` = `oerr` = 0, state IDLE, bit counter 0 and baud counter 0. Both synchroniser flops preset to 1.
- `rxd` passes through a 2-flop synchroniser, giving `rs`. A third flop holds `rs_d` for edge detection. All decisions use `rs` only.
- IDLE: when `rs_d` = 1 and `rs` = 0 (falling edge), go to START and load the baud counter with `Half - 1`.
- START: when the counter reaches 0, sample `rs`.
  - If 0: go to DATA, load `Ticks - 1`, bit index 0.
  - If 1: glitch. Return to IDLE. No flag changes.
- DATA: on each counter expiry, shift `rs` into bit[index] (LSB first) and reload `Ticks - 1`. After index 7, go to STOP with stop index 0.
- STOP: on each counter expiry, sample `rs`.
  - If 0: set `ferr`, discard the byte, go to BREAK.
  - If 1 and this is the last stop bit (`Stop - 1`): commit the byte and go to IDLE. Otherwise reload and advance.
- BREAK: wait until `rs` = 1, then go to IDLE. A line held low never produces further frames.
- Commit when `rdy` = 0, or when `rdy` = 1 and `ack` is high in the same cycle: `data` ← byte, `rdy` ← 1.
- Commit when `rdy` = 1 and `ack` = 0: `data` is unchanged (the first byte is kept), `oerr` ← 1, and the new byte is dropped.
- `ack` = 1 with no commit in that cycle: `rdy`, `ferr` and `oerr` clear on the next edge.
- `ack` and a framing error in the same cycle: `ferr` ends at 1, because set wins over clear for flags.
- `ack` while `rdy` = 0: no effect except clearing error flags.
- Reset asserted mid-frame aborts immediately to reset values. After release, reception resumes only on a fresh falling edge of `rs`.

## Timing
- `t0` is the clock edge at which IDLE sees the falling edge of `rs`. `rs` lags `rxd` by 2 cycles.
- Start sample: `t0 + Half`.
- Data bit k (0..7) sample: `t0 + Half + (k+1)·Ticks`.
- Stop bit s sample: `t0 + Half + (9+s)·Ticks`.
- `rdy`, `data`, `ferr` and `oerr` update on the edge after the last stop-bit sample, or after the failing stop sample for `ferr`.
- A new start bit is accepted from the cycle after return to IDLE. Back-to-back frames with exactly `Stop` stop bits are received without loss.
- Tolerated baud mismatch: within ±(Half / (10 + Stop)) cycles of accumulated drift over a frame.
- All outputs are registered. There is no combinational path from `rxd` or `ack` to any output.

## Test plan
- `uart_tx` (Stop=2, data 8'hA5) drives `uart_rx` (Stop=2) at 50 MHz / 9600. Required: `rdy` rises once per frame, `data` = 8'hA5, `ferr` = `oerr` = 0, rise time matches `t0 + Half + 10·Ticks + 1`.
- Transmitter Stop=4 with 8'h5A, receiver Stop=4, repeated frames, `ack` pulsed 1 cycle after each `rdy`. Required: every frame gives `data` = 8'h5A with no lost or duplicated `rdy`.
- `rxd` low for 1000 cycles (< `Half`), then high. Required: state returns to IDLE and `rdy`, `ferr` and `oerr` stay 0.
- Frame 8'h3C with the first stop bit forced low, `rxd` then held low for 3·`Ticks` before idling. Required: `ferr` = 1, `rdy` = 0, no frame detected during the low period. `ack` clears `ferr`, and a following 8'h81 frame gives `data` = 8'h81.
- Frames 8'h11 then 8'h22 with no `ack`. Required: `data` = 8'h11, `rdy` = 1, `oerr` = 1. `ack` clears both flags. A third frame 8'h33 sent with `ack` coincident with its commit gives `data` = 8'h33, `rdy` = 1, `oerr` = 0.
- `reset` pulsed low during data bit 4 of a frame. Required: all outputs 0 immediately. The remaining bits of the aborted frame do not produce `rdy`, and the next complete frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Asynchronous serial receiver. The frame is 1 start bit, 8 data bits (LSB
// first), no parity and Stop stop bits. rxd goes through a two-flop
// synchroniser. The start bit is checked again at mid-bit to reject glitches.
// Data and stop bits are sampled at mid-bit. Each good byte is placed in a
// holding register that the consumer acknowledges. The register carries
// framing and overrun error flags.
//
// Parameters:
//   Clock : system clock frequency in Hz
//   Baud  : bit rate
//   Stop  : number of stop bits checked (1..4)
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low reset
//   rxd   : serial input, idle high, asynchronous to clock
//   ack   : consumer acknowledge; clears rdy, ferr and oerr
//   data  : last good received byte
//   rdy   : data holds an unacknowledged byte
//   ferr  : sticky framing error (a stop bit was sampled low)
//   oerr  : sticky overrun (a frame completed while rdy was set)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int Clock = 50000000,
    parameter int Baud  = 9600,
    parameter int Stop  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    input  logic       ack,
    output logic [7:0] data,
    output logic       rdy,
    output logic       ferr,
    output logic       oerr
);

    localparam int Ticks = Clock / Baud;
    localparam int Half  = Ticks / 2;
    localparam int CW    = (Ticks > 2) ? $clog2(Ticks) : 1;

    localparam logic [CW-1:0] TICKS_M1  = CW'(Ticks - 1);
    localparam logic [CW-1:0] HALF_M1   = CW'(Half - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [1:0]    LAST_STOP = 2'(Stop - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchroniser and edge-detect flops. All three preset to 1 so that an
    // idle line causes no edge when reset is released.
    logic          r_sync;
    logic          r_rs;
    logic          r_rs_d;

    state_t        r_state,      w_state_next;
    logic [CW-1:0] r_cnt,        w_cnt_next;
    logic [2:0]    r_bit_idx,    w_bit_idx_next;
    logic [1:0]    r_stop_idx,   w_stop_idx_next;
    logic [7:0]    r_shift,      w_shift_next;
    // One-cycle pulses raised by the last stop sample (good frame) or by a
    // failing stop sample. The holding register acts on them one edge later.
    logic          r_done,       w_done_next;
    logic          r_fail,       w_fail_next;

    logic [7:0]    w_data_next;
    logic          w_rdy_next;
    logic          w_ferr_next;
    logic          w_oerr_next;
    logic          w_tick;

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= 1'b1;
            r_rs   <= 1'b1;
            r_rs_d <= 1'b1;
        end else begin
            r_sync <= rxd;
            r_rs   <= r_sync;
            r_rs_d <= r_rs;
        end
    end

    // Receive FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_shift    <= w_shift_next;
            r_done     <= w_done_next;
            r_fail     <= w_fail_next;
        end
    end

    // Receive FSM: next state. The baud counter counts down, and a sample is
    // taken on the cycle where it reads zero.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_shift_next    = r_shift;
        w_done_next     = 1'b0;
        w_fail_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_rs_d && !r_rs) begin
                    w_state_next = S_START;
                    w_cnt_next   = HALF_M1;
                end
            end

            S_START: begin
                if (w_tick) begin
                    if (!r_rs) begin
                        w_state_next   = S_DATA;
                        w_cnt_next     = TICKS_M1;
                        w_bit_idx_next = '0;
                    end else begin
                        // Line went back high before mid-bit: treat it as noise.
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    w_shift_next[r_bit_idx] = r_rs;
                    w_cnt_next              = TICKS_M1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next    = S_STOP;
                        w_stop_idx_next = '0;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end

            S_STOP: begin
                if (w_tick) begin
                    if (!r_rs) begin
                        w_fail_next  = 1'b1;
                        w_state_next = S_BREAK;
                    end else if (r_stop_idx == LAST_STOP) begin
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_idx_next = r_stop_idx + 2'd1;
                        w_cnt_next      = TICKS_M1;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end

            // A line held low (break or a broken frame) must return high
            // before a new start edge can be recognised.
            S_BREAK: begin
                if (r_rs) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Holding register. A completed frame loads data only if the register
    // is free or is being acknowledged in the same cycle. Otherwise the
    // first byte is kept and the overrun flag is set. For the error flags,
    // setting takes priority over ack.
    always_comb begin
        w_data_next = data;
        w_rdy_next  = rdy;

        if (r_done && (!rdy || ack)) begin
            w_data_next = r_shift;
            w_rdy_next  = 1'b1;
        end else if (ack) begin
            w_rdy_next = 1'b0;
        end

        w_ferr_next = r_fail | (ferr & ~ack);
        w_oerr_next = (r_done & rdy & ~ack) | (oerr & ~ack);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data <= '0;
            rdy  <= 1'b0;
            ferr <= 1'b0;
            oerr <= 1'b0;
        end else begin
            data <= w_data_next;
            rdy  <= w_rdy_next;
            ferr <= w_ferr_next;
            oerr <= w_oerr_next;
        end
    end

endmodule
